// File: rtl/dino_audio_pkg.sv
// Shared constants for the game audio path: melody ROMs, sequencer FSM encodings
// and the pitch-scaling helper.
package dino_audio_pkg;

   localparam int NOTE_COUNT = 4;

   // Raw half-period (clock cycles) per note; 0 marks a rest.
   localparam logic [15:0] HALF_PERIOD [NOTE_COUNT] = '{16'd28409, 16'd21276, 16'd0, 16'd14204};
   localparam logic [7:0]  DUR_UNITS   [NOTE_COUNT] = '{8'd6, 8'd6, 8'd2, 8'd12};

   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_PLAY = 2'd1;
   localparam logic [1:0] ST_GAP  = 2'd2;

   // Pitch-shifted half-period; a real note never collapses into a rest.
   function automatic logic [15:0] scaled_half(input logic [15:0] raw, input int unsigned shift);
      logic [15:0] s;
      s = raw >> shift;
      if (raw != 16'd0 && s == 16'd0) s = 16'd1;
      return s;
   endfunction

endpackage

// File: rtl/tone_divider.sv
// Half-period down-counter producing a square-wave phase; a zero period is a rest
// and holds the phase low.
module tone_divider #(
   parameter int DIV_W = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             load,
   input  logic             enable,
   input  logic [DIV_W-1:0] half,
   output logic             phase_next
);

   logic [DIV_W-1:0] count, count_next;
   logic [DIV_W-1:0] period, period_next;
   logic             phase;

   // NOTE: every comb output gets a default first so no path infers a latch.
   always_comb begin
      count_next  = count;
      period_next = period;
      phase_next  = phase;
      if (load) begin
         period_next = half;
         count_next  = (half == '0) ? '0 : half - 1'b1;
         phase_next  = 1'b0;
      end else if (enable && period != '0) begin
         if (count == '0) begin
            count_next = period - 1'b1;
            phase_next = ~phase;
         end else begin
            count_next = count - 1'b1;
         end
      end
   end

   // NOTE: state registers use non-blocking assignments so all flops update together.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         count  <= '0;
         period <= '0;
         phase  <= 1'b0;
      end else begin
         count  <= count_next;
         period <= period_next;
         phase  <= phase_next;
      end
   end

endmodule

// File: rtl/melody_sequencer.sv
// Triggered chime player: plays the package melody as a square wave, each note
// followed by a silent gap. Optional restart-on-trigger: MELODY_RETRIGGER_EN.
module melody_sequencer #(
   parameter int DIV_W       = 16,
   parameter int DUR_W       = 24,
   parameter int DUR_SHIFT   = 16,
   parameter int PITCH_SHIFT = 0,
   parameter int GAP_CYCLES  = 4096
) (
   input  logic clk,
   input  logic rst_n,
   input  logic trigger,
   input  logic mute,
   output logic wave_out,
   output logic busy,
   output logic done
);
   import dino_audio_pkg::*;

   localparam int IDX_W = (NOTE_COUNT > 1) ? $clog2(NOTE_COUNT) : 1;

`ifdef MELODY_RETRIGGER_EN
   localparam bit RETRIGGER = 1'b1;
`else
   localparam bit RETRIGGER = 1'b0;
`endif

   logic [DIV_W-1:0] half_tab [NOTE_COUNT];
   logic [DUR_W-1:0] dur_tab  [NOTE_COUNT];

   for (genvar i = 0; i < NOTE_COUNT; i++) begin : g_tab
      localparam longint unsigned DUR_FULL = 64'(DUR_UNITS[i]) << DUR_SHIFT;
      if (DUR_FULL == 0 || DUR_FULL >= (64'd1 << DUR_W)) begin : g_dur_bad
         $error("melody_sequencer: note duration does not fit DUR_W");
      end
      assign half_tab[i] = DIV_W'(scaled_half(HALF_PERIOD[i], PITCH_SHIFT));
      assign dur_tab[i]  = DUR_W'(DUR_FULL);
   end

   if (GAP_CYCLES < 1 || longint'(GAP_CYCLES) >= (64'd1 << DUR_W)) begin : g_gap_bad
      $error("melody_sequencer: GAP_CYCLES out of range");
   end

   logic [1:0]       state, state_next;
   logic [IDX_W-1:0] note_idx, idx_next;
   logic [DUR_W-1:0] dur_cnt, dur_next;
   logic             done_next;
   logic             load, enable, phase_next;

   always_comb begin
      state_next = state;
      idx_next   = note_idx;
      dur_next   = dur_cnt;
      done_next  = 1'b0;
      load       = 1'b0;
      case (state)
         ST_IDLE: if (trigger) begin
            state_next = ST_PLAY;
            idx_next   = '0;
            dur_next   = dur_tab[0] - 1'b1;
            load       = 1'b1;
         end
         ST_PLAY: if (dur_cnt == '0) begin
            state_next = ST_GAP;
            dur_next   = DUR_W'(GAP_CYCLES - 1);
         end else begin
            dur_next = dur_cnt - 1'b1;
         end
         ST_GAP: if (dur_cnt == '0) begin
            if (note_idx == IDX_W'(NOTE_COUNT - 1)) begin
               state_next = ST_IDLE;
               done_next  = 1'b1;
            end else begin
               state_next = ST_PLAY;
               idx_next   = note_idx + 1'b1;
               dur_next   = dur_tab[idx_next] - 1'b1;
               load       = 1'b1;
            end
         end else begin
            dur_next = dur_cnt - 1'b1;
         end
         default: state_next = ST_IDLE;
      endcase
      // A restart overrides the normal transition, including a pending done.
      if (RETRIGGER && trigger && state != ST_IDLE) begin
         state_next = ST_PLAY;
         idx_next   = '0;
         dur_next   = dur_tab[0] - 1'b1;
         done_next  = 1'b0;
         load       = 1'b1;
      end
   end

   assign enable = (state == ST_PLAY) && (state_next == ST_PLAY) && !load;

   tone_divider #(.DIV_W(DIV_W)) u_tone (
      .clk        (clk),
      .rst_n      (rst_n),
      .load       (load),
      .enable     (enable),
      .half       (half_tab[idx_next]),
      .phase_next (phase_next)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state    <= ST_IDLE;
         note_idx <= '0;
         dur_cnt  <= '0;
         wave_out <= 1'b0;
         busy     <= 1'b0;
         done     <= 1'b0;
      end else begin
         state    <= state_next;
         note_idx <= idx_next;
         dur_cnt  <= dur_next;
         wave_out <= (state_next == ST_PLAY) && phase_next && !mute;
         busy     <= (state_next != ST_IDLE);
         done     <= done_next;
      end
   end

endmodule

// File: tb/tb_melody_sequencer.sv
// Directed bench for melody_sequencer: per-cycle scoreboard of wave_out/busy/done
// against an offset-based reference of the melody timeline.
module tb_melody_sequencer;

   localparam int NOTES = 4;
   localparam int GAP   = 8;
   localparam int H_EXP [NOTES] = '{110, 83, 0, 55};
   localparam int D_EXP [NOTES] = '{96, 96, 32, 192};
   localparam int TOTAL = 448;

`ifdef MELODY_RETRIGGER_EN
   localparam bit RETRIG = 1'b1;
`else
   localparam bit RETRIG = 1'b0;
`endif

   typedef struct packed {
      logic wave;
      logic busy;
      logic done;
   } obs_t;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   logic trigger = 1'b0;
   logic mute = 1'b0;
   logic wave_out, busy, done;

   int   checks = 0;
   int   failures = 0;
   int   cycle = 0;
   obs_t exp_q [$];

   bit   m_active = 1'b0;
   bit   m_done = 1'b0;
   int   m_off = 0;

   melody_sequencer #(
      .DIV_W       (16),
      .DUR_W       (24),
      .DUR_SHIFT   (4),
      .PITCH_SHIFT (8),
      .GAP_CYCLES  (GAP)
   ) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .trigger  (trigger),
      .mute     (mute),
      .wave_out (wave_out),
      .busy     (busy),
      .done     (done)
   );

   always #5 clk = ~clk;

   function automatic obs_t model_out(input bit active, input int off, input bit dn, input bit mut);
      obs_t r;
      int   base;
      r      = '0;
      r.busy = active;
      r.done = dn;
      base   = 0;
      if (active) begin
         for (int k = 0; k < NOTES; k++) begin
            if (off >= base && off < base + D_EXP[k] && H_EXP[k] != 0)
               r.wave = (((off - base) / H_EXP[k]) % 2) == 1;
            base += D_EXP[k] + GAP;
         end
         if (mut) r.wave = 1'b0;
      end
      return r;
   endfunction

   task automatic compare(input string tag, input obs_t got, input obs_t want);
      checks++;
      assert (got === want) else begin
         failures++;
         $error("FAIL %s cycle=%0d observed wave/busy/done=%b expected=%b", tag, cycle, got, want);
      end
   endtask

   task automatic step(input bit trig, input bit mut);
      obs_t got;
      obs_t want;
      bit   was_active;
      @(negedge clk);
      trigger = trig;
      mute    = mut;
      @(posedge clk);
      cycle++;
      was_active = m_active;
      m_done     = 1'b0;
      if (m_active) begin
         m_off++;
         if (m_off == TOTAL) begin
            m_active = 1'b0;
            m_done   = 1'b1;
         end
      end
      if (trig && (!was_active || RETRIG)) begin
         m_active = 1'b1;
         m_off    = 0;
         m_done   = 1'b0;
      end
      exp_q.push_back(model_out(m_active, m_off, m_done, mut));
      #1;
      got.wave = wave_out;
      got.busy = busy;
      got.done = done;
      want = exp_q.pop_front();
      compare("timeline", got, want);
   endtask

   task automatic check_idle_outputs(input string tag);
      obs_t got;
      got.wave = wave_out;
      got.busy = busy;
      got.done = done;
      compare(tag, got, obs_t'('0));
   endtask

   initial begin
      repeat (2) @(posedge clk);
      #1 check_idle_outputs("reset");
      @(negedge clk);
      rst_n = 1'b1;

      repeat (3) step(1'b0, 1'b0);

      // Full melody; the trigger after the done step lands in the done cycle.
      step(1'b1, 1'b0);
      repeat (TOTAL) step(1'b0, 1'b0);
      step(1'b1, 1'b0);

      // Mute across the note-1 high phase; sequencing must be unaffected.
      for (int k = 1; k <= TOTAL; k++) step(1'b0, (k >= 150 && k <= 200));
      repeat (2) step(1'b0, 1'b0);

      // Second trigger mid-melody.
      step(1'b1, 1'b0);
      for (int k = 1; k <= 510; k++) step(k == 50, 1'b0);

      // Asynchronous reset mid-melody, then a fresh full run.
      step(1'b1, 1'b0);
      repeat (199) step(1'b0, 1'b0);
      rst_n = 1'b0;
      #1 check_idle_outputs("async_reset");
      m_active = 1'b0;
      m_done   = 1'b0;
      m_off    = 0;
      @(negedge clk);
      rst_n = 1'b1;
      repeat (3) step(1'b0, 1'b0);
      step(1'b1, 1'b0);
      repeat (TOTAL + 4) step(1'b0, 1'b0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
